// File: rtl/game_io_writer_pkg.sv
// Shared types and constants for the game I/O register writer.
package game_io_pkg;

  // Handshake channel states; see io_channel for their meaning.
  typedef enum logic [1:0] {
    IDLE,
    PEND,
    ISSUE,
    SENT
  } chan_state_t;

  // Value written into r20/r22/r24 during an event strobe.
  localparam logic [31:0] EVENT_VALUE = 32'd1;

  // Width of a down-counter that must hold the reload value of a debouncer.
  function automatic int debounce_w(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/game_io_writer_if.sv
// Register-file side bus of the game I/O writer: event data, write strobes,
// frame counter, pause level, and the processor-visible r20/r22 values.
interface game_io_writer_if;
  logic [31:0] q_reg20;
  logic [31:0] q_reg22;
  logic [31:0] r20;
  logic        button_signal_reg;
  logic [31:0] r22;
  logic        screen_signal_reg;
  logic [31:0] r24;
  logic        collision_signal_reg;
  logic [31:0] r26;
  logic        pause_signal_reg;

  // Writer side: produces register data and strobes, watches r20/r22.
  modport master (
    input  q_reg20, q_reg22,
    output r20, button_signal_reg,
    output r22, screen_signal_reg,
    output r24, collision_signal_reg,
    output r26, pause_signal_reg
  );

  // Register-file side: consumes strobes/data, reports r20/r22 contents.
  modport slave (
    output q_reg20, q_reg22,
    input  r20, button_signal_reg,
    input  r22, screen_signal_reg,
    input  r24, collision_signal_reg,
    input  r26, pause_signal_reg
  );
endinterface

// File: rtl/game_io_writer_channel.sv
// One consume-handshake channel: holds a single outstanding event until the
// processor has cleared its register, then issues a one-cycle write strobe.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | nothing outstanding; an event moves to PEND
//   PEND  | event held; waits for the register to read back as zero
//   ISSUE | strobe and data = 1 this cycle
//   SENT  | waits for the register to show the write (q != 0)
//
// Events seen outside IDLE are dropped. On the SENT exit cycle the IDLE
// decision is taken at once, so an event in that cycle is kept.
module io_channel
  import game_io_pkg::*;
(
  input  logic        clock,
  input  logic        rst_n,
  input  logic        trig,
  input  logic [31:0] q,
  output logic        strobe,
  output logic [31:0] data
);

  chan_state_t state, state_nxt;

  // State register; strobe and data are registered from the next state so
  // they line up with ISSUE.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      strobe <= 1'b0;
      data   <= '0;
    end else begin
      state  <= state_nxt;
      strobe <= (state_nxt == ISSUE);
      data   <= (state_nxt == ISSUE) ? EVENT_VALUE : '0;
    end
  end

  // Next-state decision.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trig) state_nxt = PEND;
      PEND:    if (q == '0) state_nxt = ISSUE;
      ISSUE:   state_nxt = SENT;
      SENT:    if (q != '0) state_nxt = trig ? PEND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/game_io_writer_debounce.sv
// Synchronizer plus stability filter for one asynchronous input. The accepted
// level follows the synchronized input only after DEBOUNCE_CYCLES consecutive
// samples that differ from it; rise pulses for one cycle when it goes high.
module io_debounce
  import game_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clock,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  localparam int                  DEBOUNCE_W = debounce_w(DEBOUNCE_CYCLES);
  localparam logic [DEBOUNCE_W-1:0] RELOAD   = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [DEBOUNCE_W-1:0]  remaining;
  logic                   level;
  logic                   sample;

  assign sample = sync[SYNC_STAGES-1];

  // Metastability chain; raw enters at bit 0 and leaves at the top bit.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= (sync << 1) | SYNC_STAGES'(raw);
    end
  end

  // Down-counter restarts whenever the sample agrees with the accepted level;
  // reaching zero on a disagreeing sample means the run was long enough.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      level     <= 1'b0;
      remaining <= RELOAD;
      rise      <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sample == level) begin
        remaining <= RELOAD;
      end else if (remaining == '0) begin
        level     <= sample;
        remaining <= RELOAD;
        rise      <= sample;
      end else begin
        remaining <= remaining - 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_io_writer.sv
// Turns raw game inputs into write strobes and data for the processor's
// hardware-written register slots: jump button -> r20, frame tick -> r22,
// collision -> r24, frame counter -> r26, plus a paused level.
module game_io_writer
  import game_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              button_raw,
  input  logic              pause_raw,
  input  logic              collision_raw,
  input  logic              vsync_tick,
  game_io_writer_if.master  bus
);

  logic        button_rise;
  logic        pause_rise;
  logic        collision_rise;
  logic        collision_strobe;
  logic [31:0] collision_data;
  logic        paused;
  logic [31:0] frame_count;

  io_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_button_db (
    .clock (clock),
    .rst_n (ctrl_reset_n),
    .raw   (button_raw),
    .rise  (button_rise)
  );

  io_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_pause_db (
    .clock (clock),
    .rst_n (ctrl_reset_n),
    .raw   (pause_raw),
    .rise  (pause_rise)
  );

  // The collision level is already clean; a one-sample filter leaves just
  // the synchronizer and the edge detector.
  io_debounce #(
    .DEBOUNCE_CYCLES (1),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_collision_db (
    .clock (clock),
    .rst_n (ctrl_reset_n),
    .raw   (collision_raw),
    .rise  (collision_rise)
  );

  io_channel u_button_ch (
    .clock  (clock),
    .rst_n  (ctrl_reset_n),
    .trig   (button_rise),
    .q      (bus.q_reg20),
    .strobe (bus.button_signal_reg),
    .data   (bus.r20)
  );

  io_channel u_screen_ch (
    .clock  (clock),
    .rst_n  (ctrl_reset_n),
    .trig   (vsync_tick),
    .q      (bus.q_reg22),
    .strobe (bus.screen_signal_reg),
    .data   (bus.r22)
  );

  // Collision has no handshake: every rising edge is a one-cycle write.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      collision_strobe <= 1'b0;
      collision_data   <= '0;
    end else begin
      collision_strobe <= collision_rise;
      collision_data   <= collision_rise ? EVENT_VALUE : '0;
    end
  end

  // Each accepted pause press flips the paused level.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      paused <= 1'b0;
    end else if (pause_rise) begin
      paused <= ~paused;
    end
  end

  // Frame counter; reads paused before a same-cycle toggle lands, and
  // wraps naturally at 32 bits.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      frame_count <= '0;
    end else if (vsync_tick && !paused) begin
      frame_count <= frame_count + 32'd1;
    end
  end

  assign bus.collision_signal_reg = collision_strobe;
  assign bus.r24                  = collision_data;
  assign bus.r26                  = frame_count;
  assign bus.pause_signal_reg     = paused;

endmodule

// File: tb/tb_game_io_writer.sv
// Bench for game_io_writer: a register-file model acknowledges events, a
// behavioural model predicts every output each cycle, and directed scenarios
// pin latency, coalescing, pause, wrap, collision and reset behaviour.
module tb_game_io_writer;
  localparam int DB = 40;
  localparam int SS = 2;

  logic clock = 1'b0;
  logic ctrl_reset_n = 1'b0;
  logic button_raw = 1'b0;
  logic pause_raw = 1'b0;
  logic collision_raw = 1'b0;
  logic vsync_tick = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  game_io_writer_if bus();

  game_io_writer #(.DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SS)) dut (
    .clock         (clock),
    .ctrl_reset_n  (ctrl_reset_n),
    .button_raw    (button_raw),
    .pause_raw     (pause_raw),
    .collision_raw (collision_raw),
    .vsync_tick    (vsync_tick),
    .bus           (bus)
  );

  always #5 clock = ~clock;

  // ---------------- register file / processor model ----------------
  logic        hold20 = 1'b0;
  logic        rand_ack = 1'b0;
  logic [31:0] q20 = '0;
  logic [31:0] q22 = '0;
  assign bus.q_reg20 = q20;
  assign bus.q_reg22 = q22;

  always @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      q20 <= '0;
      q22 <= '0;
    end else begin
      if (hold20) q20 <= 32'd1;
      else if (bus.button_signal_reg) q20 <= bus.r20;
      else if (q20 != 0 && (!rand_ack || $urandom_range(0, 3) == 0)) q20 <= bus.r20;
      if (bus.screen_signal_reg) q22 <= bus.r22;
      else if (q22 != 0 && (!rand_ack || $urandom_range(0, 3) == 0)) q22 <= bus.r22;
    end
  end

  // ---------------- behavioural model ----------------
  // Per input (0 button, 1 pause, 2 collision): two-cycle delay line, run
  // length of the latest equal samples, accepted level, event this cycle.
  bit [2:0]    dly_a, dly_b, runv, acc, evt;
  int          run [3];
  int          need [3];
  bit [1:0]    busy, ack_wait, exp_str;
  bit          exp_col, exp_pause;
  logic [31:0] exp_cnt;
  longint      cycle = 0;

  initial begin
    need[0] = DB; need[1] = DB; need[2] = 1;
  end

  always @(posedge clock) cycle <= cycle + 1;

  always @(posedge clock) begin : model_p
    bit          samp;
    bit          s;
    bit [2:0]    raw_now;
    bit [1:0]    ev;
    logic [31:0] qv [2];
    if (!ctrl_reset_n) begin
      dly_a = '0; dly_b = '0; runv = '0; acc = '0; evt = '0;
      for (int i = 0; i < 3; i++) run[i] = 0;
      busy = '0; ack_wait = '0; exp_str = '0;
      exp_col = 1'b0; exp_pause = 1'b0; exp_cnt = '0;
    end else begin
      // Effects of the cycle that ends at this edge.
      if (vsync_tick && !exp_pause) exp_cnt = exp_cnt + 32'd1;
      if (evt[1]) exp_pause = !exp_pause;
      exp_col = evt[2];
      ev[0] = evt[0]; ev[1] = vsync_tick;
      qv[0] = bus.q_reg20; qv[1] = bus.q_reg22;
      for (int c = 0; c < 2; c++) begin
        s = 1'b0;
        if (exp_str[c]) ack_wait[c] = 1'b1;
        else if (ack_wait[c]) begin
          if (qv[c] != 0) begin ack_wait[c] = 1'b0; busy[c] = ev[c]; end
        end
        else if (busy[c]) s = (qv[c] == 0);
        else busy[c] = ev[c];
        exp_str[c] = s;
      end
      // Input filters produce the events of the cycle that starts now.
      raw_now = {collision_raw, pause_raw, button_raw};
      for (int i = 0; i < 3; i++) begin
        samp = dly_b[i]; dly_b[i] = dly_a[i]; dly_a[i] = raw_now[i];
        if (samp == runv[i]) begin
          if (run[i] < need[i]) run[i]++;
        end else begin
          runv[i] = samp; run[i] = 1;
        end
        evt[i] = 1'b0;
        if (runv[i] != acc[i] && run[i] >= need[i]) begin
          acc[i] = runv[i];
          evt[i] = acc[i];
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_true(input string name, input bit ok, input longint act, input longint exp);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_r20"}, bus.r20, 32'd0);
    check({tag, "_btn_strobe"}, {31'd0, bus.button_signal_reg}, 32'd0);
    check({tag, "_r22"}, bus.r22, 32'd0);
    check({tag, "_scr_strobe"}, {31'd0, bus.screen_signal_reg}, 32'd0);
    check({tag, "_r24"}, bus.r24, 32'd0);
    check({tag, "_col_strobe"}, {31'd0, bus.collision_signal_reg}, 32'd0);
    check({tag, "_r26"}, bus.r26, 32'd0);
    check({tag, "_pause"}, {31'd0, bus.pause_signal_reg}, 32'd0);
  endtask

  bit model_on = 1'b0;

  always @(negedge clock) begin
    if (ctrl_reset_n && model_on) begin
      check("m_btn_strobe", {31'd0, bus.button_signal_reg}, {31'd0, exp_str[0]});
      check("m_r20", bus.r20, exp_str[0] ? 32'd1 : 32'd0);
      check("m_scr_strobe", {31'd0, bus.screen_signal_reg}, {31'd0, exp_str[1]});
      check("m_r22", bus.r22, exp_str[1] ? 32'd1 : 32'd0);
      check("m_col_strobe", {31'd0, bus.collision_signal_reg}, {31'd0, exp_col});
      check("m_r24", bus.r24, exp_col ? 32'd1 : 32'd0);
      check("m_r26", bus.r26, exp_cnt);
      check("m_pause", {31'd0, bus.pause_signal_reg}, {31'd0, exp_pause});
    end
  end

  int n_btn = 0, n_scr = 0, n_col = 0;
  always @(negedge clock) begin
    if (ctrl_reset_n) begin
      if (bus.button_signal_reg) n_btn++;
      if (bus.screen_signal_reg) n_scr++;
      if (bus.collision_signal_reg) n_col++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic tick();
    vsync_tick = 1'b1;
    @(negedge clock);
    vsync_tick = 1'b0;
  endtask

  task automatic press(input bit which_pause, input int len);
    if (which_pause) pause_raw = 1'b1; else button_raw = 1'b1;
    cycles(len);
    if (which_pause) pause_raw = 1'b0; else button_raw = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int     base;
    bit     got;
    longint t0, lat;
    int     hb, hp, hc;

    // Reset state.
    ctrl_reset_n = 1'b0;
    cycles(3);
    check_all_zero("in_reset");
    ctrl_reset_n = 1'b1;
    model_on = 1'b1;
    cycles(1);
    check_all_zero("after_reset");

    // Held button press: one strobe, at the expected latency.
    base = n_btn;
    t0 = cycle;
    button_raw = 1'b1;
    got = 1'b0;
    for (int i = 0; i < DB + 20; i++) begin
      @(negedge clock);
      if (bus.button_signal_reg) begin got = 1'b1; break; end
    end
    lat = cycle - t0;
    check_true("btn_latency", got && lat >= DB + SS + 1 && lat <= DB + SS + 3, lat, DB + SS + 2);
    check("btn_r20_on_strobe", bus.r20, 32'd1);
    cycles(2 * DB);
    button_raw = 1'b0;
    cycles(DB + 20);
    check_true("btn_one_pulse", n_btn - base == 1, n_btn - base, 1);

    // Bouncing faster than the filter: no strobe.
    base = n_btn;
    for (int i = 0; i < 50; i++) begin
      button_raw = ~button_raw;
      cycles(10);
    end
    button_raw = 1'b0;
    cycles(DB + 20);
    check_true("bounce_no_strobe", n_btn - base == 0, n_btn - base, 0);

    // Unconsumed r20 blocks the strobe; a second press coalesces.
    hold20 = 1'b1;
    cycles(2);
    base = n_btn;
    press(1'b0, DB + 10);
    cycles(DB + 10);
    press(1'b0, DB + 10);
    cycles(DB + 10);
    check_true("held_q_no_strobe", n_btn - base == 0, n_btn - base, 0);
    hold20 = 1'b0;
    cycles(2);
    check("released_q_strobe", {31'd0, bus.button_signal_reg}, 32'd1);
    cycles(3 * DB);
    check_true("coalesced_one_pulse", n_btn - base == 1, n_btn - base, 1);

    // Three frames with prompt clearing, then pause freezes the count.
    base = n_scr;
    for (int i = 0; i < 3; i++) begin
      tick();
      cycles(8);
    end
    check_true("three_screen_strobes", n_scr - base == 3, n_scr - base, 3);
    check("r26_after_three", bus.r26, 32'd3);
    press(1'b1, DB + 10);
    cycles(DB + 10);
    tick(); cycles(8);
    tick(); cycles(8);
    check("r26_while_paused", bus.r26, 32'd3);
    check("pause_level_set", {31'd0, bus.pause_signal_reg}, 32'd1);

    // Unpause, then wrap from all-ones.
    press(1'b1, DB + 10);
    cycles(DB + 10);
    check("pause_level_clear", {31'd0, bus.pause_signal_reg}, 32'd0);
    exp_cnt = 32'hFFFF_FFFF;
    force dut.frame_count = 32'hFFFF_FFFF;
    cycles(2);
    release dut.frame_count;
    tick();
    check("r26_wrap", bus.r26, 32'd0);
    cycles(8);

    // Collision held across ten frames: one event.
    base = n_col;
    collision_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      cycles(20);
    end
    collision_raw = 1'b0;
    cycles(10);
    check_true("collision_one_pulse", n_col - base == 1, n_col - base, 1);

    // Reset while a button event is pending discards it.
    hold20 = 1'b1;
    cycles(2);
    button_raw = 1'b1;
    cycles(DB + 8);
    ctrl_reset_n = 1'b0;
    button_raw = 1'b0;
    hold20 = 1'b0;
    cycles(2);
    check_all_zero("mid_reset");
    ctrl_reset_n = 1'b1;
    base = n_btn;
    cycles(3 * DB);
    check_true("no_strobe_after_reset", n_btn - base == 0, n_btn - base, 0);

    // Randomised traffic against the model.
    rand_ack = 1'b1;
    hb = 1; hp = 1; hc = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      vsync_tick = ($urandom_range(0, 11) == 0);
      hb = hb - 1;
      if (hb == 0) begin button_raw = ~button_raw; hb = $urandom_range(1, 2 * DB); end
      hp = hp - 1;
      if (hp == 0) begin pause_raw = ~pause_raw; hp = $urandom_range(1, 3 * DB); end
      hc = hc - 1;
      if (hc == 0) begin collision_raw = ~collision_raw; hc = $urandom_range(1, 30); end
    end
    vsync_tick = 1'b0;
    button_raw = 1'b0;
    pause_raw = 1'b0;
    collision_raw = 1'b0;
    rand_ack = 1'b0;
    cycles(3 * DB);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
